// File: rtl/interconn_arb_if.sv
// rtl/interconn_arb_if.sv - request and send bus bundle for the crossbar arbiter
interface interconn_arb_if #(
  parameter int N     = 8,
  parameter int W     = 64,
  parameter int BADDR = 15
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]            req_valid;
  logic [N-1:0][N-1:0]     req_to;
  logic [N-1:0][BADDR-1:0] req_addr;
  logic [N-1:0][W-1:0]     req_word;
  logic [N-1:0]            req_ready;

  logic [N-1:0][N-1:0]     send_to;
  logic [N-1:0]            send_en;
  logic [N-1:0][BADDR-1:0] send_addr;
  logic [N-1:0][W-1:0]     send_word;
  logic [PW-1:0]           prio_ptr;

  modport master (
    output req_valid, req_to, req_addr, req_word,
    input  req_ready, send_to, send_en, send_addr, send_word, prio_ptr
  );

  modport slave (
    input  req_valid, req_to, req_addr, req_word,
    output req_ready, send_to, send_en, send_addr, send_word, prio_ptr
  );
endinterface

// File: rtl/interconn_arb.sv
// rtl/interconn_arb.sv - round-robin crossbar arbiter granting destination-disjoint requests
module interconn_arb #(
  parameter int N     = 8,
  parameter int W     = 64,
  parameter int BADDR = 15
) (
  input  logic            clk,
  input  logic            clr,
  interconn_arb_if.slave  bus
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;
  logic [PW-1:0] first_idx;
  logic [PW-1:0] idx;
  logic [N-1:0]  grant;
  logic [N-1:0]  claimed;
  logic          found;

  // Greedy pass in rotated order; zero-mask requests are granted but never move the pointer.
  always_comb begin
    grant     = '0;
    claimed   = '0;
    found     = 1'b0;
    first_idx = '0;
    idx       = '0;
    ptr_d     = ptr_q;
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(ptr_q) + k) % N);
      if (!clr && bus.req_valid[idx] && ((bus.req_to[idx] & claimed) == '0)) begin
        grant[idx] = 1'b1;
        claimed    = claimed | bus.req_to[idx];
        if (!found && (bus.req_to[idx] != '0)) begin
          found     = 1'b1;
          first_idx = idx;
        end
      end
    end
    if (found) begin
      ptr_d = (int'(first_idx) == N - 1) ? '0 : first_idx + PW'(1);
    end
  end

  assign bus.req_ready = grant;
  assign bus.prio_ptr  = ptr_q;

  // Ungranted lanes must drive zeros because the interconnect ORs all sources together.
  always_ff @(posedge clk) begin
    if (clr) begin
      ptr_q         <= '0;
      bus.send_en   <= '0;
      bus.send_to   <= '0;
      bus.send_addr <= '0;
      bus.send_word <= '0;
    end else begin
      ptr_q <= ptr_d;
      for (int i = 0; i < N; i++) begin
        bus.send_en[i]   <= grant[i] && (bus.req_to[i] != '0);
        bus.send_to[i]   <= grant[i] ? bus.req_to[i]   : '0;
        bus.send_addr[i] <= grant[i] ? bus.req_addr[i] : '0;
        bus.send_word[i] <= grant[i] ? bus.req_word[i] : '0;
      end
    end
  end
endmodule

// File: tb/tb_interconn_arb.sv
// tb/tb_interconn_arb.sv - scoreboard bench for interconn_arb with directed vectors
module tb_interconn_arb;
  logic clk;
  logic clr;

  interconn_arb_if #(.N(8), .W(64), .BADDR(15)) bus ();

  interconn_arb #(.N(8), .W(64), .BADDR(15)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus.slave)
  );

  typedef struct {
    logic [7:0]        en;
    logic [7:0][7:0]   to;
    logic [7:0][14:0]  addr;
    logic [7:0][63:0]  word;
    logic [2:0]        ptr;
    int                id;
  } exp_t;

  exp_t       qs[$];
  logic [7:0] qr[$];
  int         qr_id[$];

  logic [7:0][7:0]  t_to;
  logic [7:0][14:0] t_addr;
  logic [7:0][63:0] t_word;

  int n_pass = 0;
  int n_total = 0;
  int vec_id = 0;
  int served[8];
  bit fair_on = 0;
  bit inv_on = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic clear_req();
    t_to = '0;
    t_addr = '0;
    t_word = '0;
  endtask

  task automatic step(input logic c, input logic [7:0] v, input logic [7:0] rdy, input logic [2:0] ptr);
    exp_t e;
    @(negedge clk);
    clr = c;
    bus.req_valid = v;
    bus.req_to = t_to;
    bus.req_addr = t_addr;
    bus.req_word = t_word;
    vec_id++;
    e.id = vec_id;
    e.ptr = ptr;
    e.en = '0;
    e.to = '0;
    e.addr = '0;
    e.word = '0;
    for (int i = 0; i < 8; i++) begin
      if (rdy[i]) begin
        e.en[i] = (t_to[i] != 8'h00);
        e.to[i] = t_to[i];
        e.addr[i] = t_addr[i];
        e.word[i] = t_word[i];
      end
    end
    qs.push_back(e);
    qr.push_back(rdy);
    qr_id.push_back(vec_id);
  endtask

  // Combinational grant is sampled mid-cycle, after the driver has settled inputs.
  always @(negedge clk) begin
    #2;
    if (qr.size() > 0) begin
      logic [7:0] r;
      int id;
      r = qr.pop_front();
      id = qr_id.pop_front();
      chk($sformatf("v%0d req_ready", id), 512'(bus.req_ready), 512'(r));
      if (fair_on)
        for (int i = 0; i < 8; i++) if (bus.req_ready[i]) served[i]++;
    end
  end

  always @(posedge clk) begin
    #1;
    if (inv_on) begin
      for (int j = 0; j < 8; j++) begin
        int cnt;
        cnt = 0;
        for (int i = 0; i < 8; i++) if (bus.send_en[i] && bus.send_to[i][j]) cnt++;
        n_total++;
        if (cnt > 1) $display("FAIL one_driver dest%0d: got %0d drivers expected at most 1", j, cnt);
        else n_pass++;
      end
    end
    if (qs.size() > 0) begin
      exp_t e;
      e = qs.pop_front();
      chk($sformatf("v%0d send_en", e.id), 512'(bus.send_en), 512'(e.en));
      chk($sformatf("v%0d send_to", e.id), 512'(bus.send_to), 512'(e.to));
      chk($sformatf("v%0d send_addr", e.id), 512'(bus.send_addr), 512'(e.addr));
      chk($sformatf("v%0d send_word", e.id), 512'(bus.send_word), 512'(e.word));
      chk($sformatf("v%0d prio_ptr", e.id), 512'(bus.prio_ptr), 512'(e.ptr));
    end
  end

  initial begin
    logic [2:0] p;
    logic [2:0] np;
    logic [7:0] r;
    clr = 1'b1;
    bus.req_valid = '0;
    clear_req();
    bus.req_to = '0;
    bus.req_addr = '0;
    bus.req_word = '0;
    for (int i = 0; i < 8; i++) served[i] = 0;
    inv_on = 1;

    step(1'b1, 8'h00, 8'h00, 3'd0);

    // single source
    t_to[2] = 8'h10; t_addr[2] = 15'd5; t_word[2] = 64'hDEAD;
    step(1'b0, 8'h04, 8'h04, 3'd3);
    step(1'b0, 8'h00, 8'h00, 3'd3);

    // conflict on destination 2
    step(1'b1, 8'h00, 8'h00, 3'd0);
    clear_req();
    t_to[0] = 8'h04; t_addr[0] = 15'd10; t_word[0] = 64'hA0;
    t_to[1] = 8'h04; t_addr[1] = 15'd11; t_word[1] = 64'hA1;
    step(1'b0, 8'h03, 8'h01, 3'd1);
    step(1'b0, 8'h03, 8'h02, 3'd2);
    step(1'b0, 8'h03, 8'h01, 3'd1);

    // disjoint ring, everyone in parallel
    step(1'b1, 8'h00, 8'h00, 3'd0);
    for (int i = 0; i < 8; i++) begin
      t_to[i] = 8'(1 << ((i + 1) % 8));
      t_addr[i] = 15'(i * 3 + 1);
      t_word[i] = 64'h1111_0000 + 64'(i);
    end
    step(1'b0, 8'hFF, 8'hFF, 3'd1);

    // zero mask: granted, discarded, pointer held
    clear_req();
    t_addr[3] = 15'd7; t_word[3] = 64'h77;
    step(1'b0, 8'h08, 8'h08, 3'd1);
    t_to[4] = 8'h01; t_addr[4] = 15'd9; t_word[4] = 64'h99;
    step(1'b0, 8'h18, 8'h18, 3'd5);

    // broadcast fairness: source 5 wants every destination
    step(1'b1, 8'h00, 8'h00, 3'd0);
    clear_req();
    for (int i = 0; i < 5; i++) begin
      t_to[i] = 8'(1 << i);
      t_addr[i] = 15'(100 + i);
      t_word[i] = 64'h1111 * 64'(i + 1);
    end
    t_to[5] = 8'hFF; t_addr[5] = 15'd105; t_word[5] = 64'hB0B0;
    fair_on = 1;
    p = 3'd0;
    for (int c = 0; c < 64; c++) begin
      if (p == 3'd5) begin r = 8'h20; np = 3'd6; end
      else if (p == 3'd6) begin r = 8'h1F; np = 3'd1; end
      else begin r = 8'h1F; np = p + 3'd1; end
      step(1'b0, 8'h3F, r, np);
      p = np;
    end
    @(posedge clk);
    fair_on = 0;
    for (int i = 0; i < 6; i++) begin
      n_total++;
      if (served[i] < 8) $display("FAIL served src%0d: got %0d grants expected at least 8", i, served[i]);
      else n_pass++;
    end

    // reset in the middle of traffic
    clear_req();
    t_to[0] = 8'h03; t_addr[0] = 15'd20; t_word[0] = 64'hC0;
    t_to[1] = 8'h02; t_addr[1] = 15'd21; t_word[1] = 64'hC1;
    t_to[2] = 8'h04; t_addr[2] = 15'd22; t_word[2] = 64'hC2;
    t_to[3] = 8'h08; t_addr[3] = 15'd23; t_word[3] = 64'hC3;
    step(1'b0, 8'h0F, 8'h0D, 3'd1);
    step(1'b0, 8'h0F, 8'h0E, 3'd2);
    step(1'b1, 8'h0F, 8'h00, 3'd0);
    step(1'b0, 8'h0F, 8'h0D, 3'd1);
    step(1'b0, 8'h00, 8'h00, 3'd1);

    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drained", 512'(qs.size() + qr.size()), 512'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/interconn_arb.md
Name: interconn_arb

Overview:
Crossbar arbiter that sits directly upstream of the MVU interconnect and drives its send_to/send_en/send_addr/send_word inputs.
- Each MVU presents one outgoing write request: a destination bitmask, an address and a data word.
- The interconnect ORs colliding traffic, so this block grants a set of requests whose destination masks are pairwise disjoint.
- Priority rotates round-robin. Granted requests are registered onto the send bus.

Parameters:
N, 8, number of MVUs (sources and destinations); N >= 1
W, 64, data word bitwidth
BADDR, 15, memory address bitwidth

Ports:
clk  input  1  clock
clr  input  1  reset; synchronous, active-high
req_valid  input  1 x [N]  source i has a pending request
req_to  input  N x [N]  destination bitmask of source i; bit j means send to MVU j
req_addr  input  BADDR x [N]  destination memory address
req_word  input  W x [N]  data word
req_ready  output  1 x [N]  combinational grant; transfer when req_valid & req_ready
send_to  output  N x [N]  registered destination mask to interconnect
send_en  output  1 x [N]  registered send enable
send_addr  output  BADDR x [N]  registered address
send_word  output  W x [N]  registered word
prio_ptr  output  $clog2(N) (min 1)  current highest-priority source (debug)

Behaviour:
- Reset (clr high at a clk edge): send_en=0, send_to=0, send_addr=0, send_word=0, prio_ptr=0 for all i. req_ready is forced to 0 while clr is high.
- Arbitration (combinational, every cycle):
  - Visit sources in order prio_ptr, prio_ptr+1, …, wrapping modulo N.
  - Keep a claimed-destination mask, initially 0.
  - Source k is granted iff req_valid[k]=1 and (req_to[k] & claimed)==0. On a grant, claimed |= req_to[k].
  - req_ready[k] = grant[k].
- A request with req_to==0 is always granted and discarded: it produces send_en=0 next cycle and claims nothing.
- Output register, 1-cycle latency: at each edge, for every source i:
  - send_en[i] = grant[i] & (req_to[i]!=0)
  - send_to[i] = grant[i] ? req_to[i] : 0
  - send_addr[i] and send_word[i] take the request value if granted, else 0.
  - Ungranted or idle sources therefore drive zeros, which the interconnect's OR-reduction requires.
- Pointer update:
  - If at least one source (with a nonzero mask) is granted, prio_ptr becomes (first granted source in visit order + 1) mod N.
  - Otherwise prio_ptr holds.
  - This guarantees every persistently valid requester becomes highest priority within N cycles. It is then granted, so no starvation even for wide broadcast masks.
- Invariant on registered outputs: for any j, at most one i has send_en[i] & send_to[i][j]. Self-send (bit i set in req_to[i]) is legal.
- Protocol:
  - A source must hold req_to/req_addr/req_word stable while req_valid=1 and req_ready=0.
  - req_valid must not depend combinationally on req_ready.
  - Holding request stability and deassertion are the source's responsibility.
- Reset mid-operation: in-flight registered outputs are cleared, no grant occurs in the clr cycle, and pending requests are re-arbitrated from prio_ptr=0 after clr drops.
- N==1: pointer is constant 0; source 0 is granted whenever valid.
- No internal buffering: throughput is one request per source per cycle when there are no conflicts.

Test Plan:
- Single source, N=8: req_valid[2]=1, req_to[2]=8'b0001_0000, addr=5, word=0xDEAD → req_ready[2]=1 the same cycle. Next cycle send_en[2]=1, send_to[2]=0x10, send_addr[2]=5, send_word[2]=0xDEAD; all other send_* are 0; prio_ptr=3.
- Conflict: sources 0 and 1 both target 0x04, held valid, ptr=0 → cycle 1 grants 0 only (ptr→1); cycle 2 grants 1 (ptr→2); never both sent in the same cycle.
- Disjoint parallel: sources 0..7 each target only MVU (i+1)%8 → all granted in one cycle; all send_en=1 the next cycle; ptr→1.
- Broadcast fairness: source 5 requests 0xFF continuously while sources 0..4 request single disjoint masks continuously → source 5 is granted within ≤8 cycles, alone in its grant cycle; all sources are served repeatedly over 64 cycles; the one-driver-per-destination invariant is checked every cycle.
- Zero mask: req_valid[3]=1, req_to[3]=0 → req_ready[3]=1; next cycle send_en[3]=0; ptr unchanged.
- Reset mid-traffic: assert clr for 1 cycle while 4 sources send → next edge all send_* are 0 and ptr=0; req_ready=0 during clr; arbitration resumes from ptr=0 afterwards.
